// File: rtl/kyber_pkg.sv
// ---------------------------------------------------------------------------
// kyber_pkg
//   Shared constants and types for the Kyber NTT datapath.
//   KYBER_Q   : coefficient modulus q = 3329
//   BARRETT_K : Barrett shift; also the product (input) width
//   BARRETT_M : floor(2^K / q)
//   COEF_W    : width of a canonical coefficient in [0, q-1]
//   PROD_W    : width of a raw 12x12 product
//   QUOT_W    : width of the Barrett quotient estimate floor(x*M / 2^K)
//   RED_W     : width holding the partially reduced value r in [0, 3q)
// ---------------------------------------------------------------------------
package kyber_pkg;

   localparam int unsigned KYBER_Q   = 3329;
   localparam int unsigned BARRETT_K = 24;
   localparam int unsigned BARRETT_M = 5039;
   localparam int unsigned COEF_W    = 12;
   localparam int unsigned PROD_W    = 24;
   localparam int unsigned QUOT_W    = 13;
   localparam int unsigned RED_W     = 14;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [PROD_W-1:0] prod_t;
   typedef logic [QUOT_W-1:0] quot_t;
   typedef logic [RED_W-1:0]  red_t;

endpackage

// File: rtl/modred_csub.sv
// ---------------------------------------------------------------------------
// modred_csub
//   Combinational conditional subtract of the modulus: y = (a >= q) ? a - q : a
//   Parameters:
//     W : operand width (must hold q)
//   Ports:
//     a : operand
//     y : a reduced by one q when a >= q
// ---------------------------------------------------------------------------
module modred_csub
   import kyber_pkg::*;
#(
   parameter int unsigned W = RED_W
)
(
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   localparam logic [W-1:0] Q_W = W'(KYBER_Q);

   always_comb begin
      y = a;
      if (a >= Q_W) begin
         y = a - Q_W;
      end
   end

endmodule

// File: rtl/modred_barrett.sv
// ---------------------------------------------------------------------------
// modred_barrett
//   Four-stage pipelined Barrett reduction of a 24-bit product modulo
//   q = 3329, returning the canonical residue in [0, q-1].
//     S1: register x
//     S2: t = floor(x * M / 2^24)
//     S3: r = x - t*q            (r < 3q, fits 14 bits)
//     S4: two conditional subtracts of q, register low 12 bits
//   All stages advance together when adv = !out_valid | out_ready; bubbles
//   occupy slots. in_ready equals adv.
//
//   Optional feature (macro MODRED_TAG_EN): a TAG_W-bit sideband tag rides
//   alongside each item and emerges on out_tag with its result. Without the
//   macro the tag ports, parameter and registers do not exist.
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high; clears valids and data regs
//     in_valid   in_data (and in_tag) valid
//     in_ready   block accepts input this cycle
//     in_data    product x, 0 .. 2^24-1
//     in_tag     sideband tag            (MODRED_TAG_EN only)
//     out_tag    tag of the same item    (MODRED_TAG_EN only)
//     out_valid  out_data valid
//     out_ready  consumer accepts output
//     out_data   x mod q
// ---------------------------------------------------------------------------
module modred_barrett
   import kyber_pkg::*;
`ifdef MODRED_TAG_EN
#(
   parameter int unsigned TAG_W = 8
)
`endif
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_data,
`ifdef MODRED_TAG_EN
   input  logic [TAG_W-1:0]  in_tag,
   output logic [TAG_W-1:0]  out_tag,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COEF_W-1:0] out_data
);

   // full-width product for the quotient estimate
   localparam int unsigned P_W = PROD_W + QUOT_W;

   logic  adv;
   logic  v1, v2, v3, v4;
   prod_t x1, x2;
   quot_t t2;
   red_t  r3;

   quot_t t_nxt;
   red_t  r_nxt;
   red_t  r_a, r_b;

   assign adv       = !v4 || out_ready;
   assign in_ready  = adv;
   assign out_valid = v4;

   // S2: quotient estimate, the upper 13 bits of the 37-bit product x*M
   always_comb begin
      t_nxt = QUOT_W'((P_W'(x1) * P_W'(BARRETT_M)) >> BARRETT_K);
   end

   // S3: remainder estimate; the true value is below 3q so 14 bits suffice
   always_comb begin
      r_nxt = RED_W'(x2 - (PROD_W'(t2) * PROD_W'(KYBER_Q)));
   end

   // S4: two conditional subtracts bring [0, 3q) into [0, q)
   modred_csub #(.W(RED_W)) u_csub_a (
      .a (r3),
      .y (r_a)
   );

   modred_csub #(.W(RED_W)) u_csub_b (
      .a (r_a),
      .y (r_b)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         v3       <= 1'b0;
         v4       <= 1'b0;
         x1       <= '0;
         x2       <= '0;
         t2       <= '0;
         r3       <= '0;
         out_data <= '0;
      end else if (adv) begin
         v1       <= in_valid;
         v2       <= v1;
         v3       <= v2;
         v4       <= v3;
         x1       <= in_data;
         x2       <= x1;
         t2       <= t_nxt;
         r3       <= r_nxt;
         out_data <= COEF_W'(r_b);
      end
   end

`ifdef MODRED_TAG_EN
   logic [TAG_W-1:0] tag1, tag2, tag3;

   // tag shift register stalls and resets in lockstep with the data stages
   always_ff @(posedge clk) begin
      if (reset) begin
         tag1    <= '0;
         tag2    <= '0;
         tag3    <= '0;
         out_tag <= '0;
      end else if (adv) begin
         tag1    <= in_tag;
         tag2    <= tag1;
         tag3    <= tag2;
         out_tag <= tag3;
      end
   end
`endif

endmodule
